// File: rtl/ddr_block_read_scheduler.sv
// Tracks written-but-unread DDR blocks and schedules block reads.
// Ports: write-done pulses in, rd_req/rd_ack/rd_done handshake, status/error flags out.
module ddr_block_read_scheduler #(
  parameter int BLOCK_AW = 12,
  parameter int TOTAL_W  = 32
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                enable_in,
  input  logic                wr_done_pulse,
  input  logic                rd_ack,
  input  logic                rd_done,
  input  logic                clear_errors,
  output logic                rd_req,
  output logic [BLOCK_AW-1:0] rd_addr,
  output logic [BLOCK_AW:0]   blocks_pending,
  output logic [TOTAL_W-1:0]  total_written,
  output logic                overflow_err,
  output logic                protocol_err,
  output logic                busy
);

  localparam logic [BLOCK_AW:0] MAXB = {1'b1, {BLOCK_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic ack_bad;
  logic done_ok;
  logic done_bad;
  logic full;
  logic inc;
  logic dec;

  always_comb begin
    done_ok  = (state == BUSY) && rd_done;
    ack_bad  = (state != REQ) && rd_ack;
    done_bad = (state != BUSY) && rd_done;
    full     = (blocks_pending == MAXB);
    // a write and a retire in the same cycle cancel out
    inc      = wr_done_pulse && !done_ok;
    dec      = done_ok && !wr_done_pulse;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable_in && (|blocks_pending)) state_nxt = REQ;
      REQ:  if (rd_ack) state_nxt = BUSY;
      BUSY: if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  assign rd_req = (state == REQ);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_addr        <= '0;
      blocks_pending <= '0;
      total_written  <= '0;
      overflow_err   <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      if (wr_done_pulse)
        total_written <= total_written + TOTAL_W'(1);
      if (inc && !full)
        blocks_pending <= blocks_pending + (BLOCK_AW+1)'(1);
      else if (dec)
        blocks_pending <= blocks_pending - (BLOCK_AW+1)'(1);
      if (done_ok)
        rd_addr <= rd_addr + BLOCK_AW'(1);
      // set beats clear when both land in one cycle
      if (inc && full)       overflow_err <= 1'b1;
      else if (clear_errors) overflow_err <= 1'b0;
      if (ack_bad || done_bad) protocol_err <= 1'b1;
      else if (clear_errors)   protocol_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_block_read_scheduler.sv
// Testbench for ddr_block_read_scheduler: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_ddr_block_read_scheduler;

  localparam int AW  = 2;
  localparam int TW  = 8;
  localparam int MAX = 1 << AW;

  logic clk_in = 1'b0;
  logic reset_in, enable_in, wr_done_pulse;
  logic rd_ack, rd_done, clear_errors;
  logic rd_req, overflow_err, protocol_err, busy;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   blocks_pending;
  logic [TW-1:0] total_written;

  always #5 clk_in = ~clk_in;

  ddr_block_read_scheduler #(.BLOCK_AW(AW), .TOTAL_W(TW)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
    .wr_done_pulse(wr_done_pulse), .rd_ack(rd_ack), .rd_done(rd_done),
    .clear_errors(clear_errors), .rd_req(rd_req), .rd_addr(rd_addr),
    .blocks_pending(blocks_pending), .total_written(total_written),
    .overflow_err(overflow_err), .protocol_err(protocol_err), .busy(busy)
  );

  int npass = 0;
  int ntotal = 0;

  // behavioural model: counts plus handshake phase
  // (0 = waiting, 1 = requesting, 2 = reading)
  int m_pend, m_tot, m_addr, m_ovf, m_perr, m_ph;

  function automatic int pack(int req, int bz, int ovf, int perr,
                              int pend, int addr, int tot);
    return (req << 16) | (bz << 15) | (ovf << 14) | (perr << 13) |
           (pend << 10) | (addr << 8) | tot;
  endfunction

  function automatic int act();
    return pack(int'(rd_req), int'(busy), int'(overflow_err),
                int'(protocol_err), int'(blocks_pending),
                int'(rd_addr), int'(total_written));
  endfunction

  function automatic int mexp();
    return pack(m_ph == 1 ? 1 : 0, m_ph != 0 ? 1 : 0, m_ovf, m_perr,
                m_pend, m_addr, m_tot);
  endfunction

  task automatic chk(input string name, input int a, input int e);
    ntotal++;
    if (a == e) npass++;
    else $display("FAIL %s: got %05h want %05h", name, a, e);
  endtask

  task automatic model_step(input int r, e, w, a, d, c);
    int dn, ak, err, ovf_ev, np, ph;
    if (r != 0) begin
      m_pend = 0; m_tot = 0; m_addr = 0;
      m_ovf = 0; m_perr = 0; m_ph = 0;
      return;
    end
    ak = (m_ph == 1 && a != 0) ? 1 : 0;
    dn = (m_ph == 2 && d != 0) ? 1 : 0;
    err = ((a != 0 && m_ph != 1) || (d != 0 && m_ph != 2)) ? 1 : 0;
    np = m_pend + w - dn;
    ovf_ev = 0;
    if (np > MAX) begin
      np = MAX;
      ovf_ev = 1;
    end
    ph = m_ph;
    if (m_ph == 0 && e != 0 && m_pend > 0) ph = 1;
    if (ak != 0) ph = 2;
    if (dn != 0) ph = 0;
    m_pend = np;
    m_tot = (m_tot + w) % (1 << TW);
    if (dn != 0) m_addr = (m_addr + 1) % MAX;
    m_ph = ph;
    if (ovf_ev != 0) m_ovf = 1;
    else if (c != 0) m_ovf = 0;
    if (err != 0) m_perr = 1;
    else if (c != 0) m_perr = 0;
  endtask

  task automatic cyc(input int r, e, w, a, d, c);
    @(negedge clk_in);
    reset_in = (r != 0);
    enable_in = (e != 0);
    wr_done_pulse = (w != 0);
    rd_ack = (a != 0);
    rd_done = (d != 0);
    clear_errors = (c != 0);
    model_step(r, e, w, a, d, c);
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    int rst, en, wr, ack, done, clr;
    int req, pend, addr, tot, ovf, perr, bz;
  } vec_t;

  vec_t vt[25];

  initial begin
    reset_in = 1'b1; enable_in = 1'b0; wr_done_pulse = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0; clear_errors = 1'b0;
    m_pend = 0; m_tot = 0; m_addr = 0; m_ovf = 0; m_perr = 0; m_ph = 0;

    //          rst en wr ak dn cl | req pend addr tot ovf perr busy
    vt[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1};
    vt[5]  = '{0, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1};
    vt[6]  = '{0, 1, 0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 1};
    vt[7]  = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 1};
    vt[8]  = '{0, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0, 0};
    vt[9]  = '{0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
    vt[10] = '{0, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1, 0};
    vt[11] = '{0, 1, 0, 0, 0, 1,   0, 0, 1, 1, 0, 0, 0};
    vt[12] = '{0, 1, 1, 0, 0, 0,   0, 1, 1, 2, 0, 0, 0};
    vt[13] = '{0, 1, 0, 0, 0, 0,   1, 1, 1, 2, 0, 0, 1};
    vt[14] = '{0, 1, 0, 1, 0, 0,   0, 1, 1, 2, 0, 0, 1};
    vt[15] = '{0, 1, 0, 1, 0, 0,   0, 1, 1, 2, 0, 1, 1};
    vt[16] = '{0, 1, 0, 0, 0, 1,   0, 1, 1, 2, 0, 0, 1};
    vt[17] = '{0, 1, 0, 0, 1, 0,   0, 0, 2, 2, 0, 0, 0};
    vt[18] = '{0, 1, 0, 1, 0, 1,   0, 0, 2, 2, 0, 1, 0};
    vt[19] = '{0, 1, 0, 0, 0, 1,   0, 0, 2, 2, 0, 0, 0};
    vt[20] = '{0, 0, 1, 0, 0, 0,   0, 1, 2, 3, 0, 0, 0};
    vt[21] = '{0, 0, 0, 0, 0, 0,   0, 1, 2, 3, 0, 0, 0};
    vt[22] = '{0, 1, 0, 0, 0, 0,   1, 1, 2, 3, 0, 0, 1};
    vt[23] = '{0, 1, 0, 1, 1, 0,   0, 1, 2, 3, 0, 1, 1};
    vt[24] = '{0, 0, 0, 0, 1, 0,   0, 0, 3, 3, 0, 1, 0};

    for (int i = 0; i < 25; i++) begin
      cyc(vt[i].rst, vt[i].en, vt[i].wr, vt[i].ack, vt[i].done, vt[i].clr);
      chk($sformatf("vec%0d", i), act(),
          pack(vt[i].req, vt[i].bz, vt[i].ovf, vt[i].perr,
               vt[i].pend, vt[i].addr, vt[i].tot));
    end

    // write-done and retire in the same cycle
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("sim_req", int'(rd_req), 1);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    chk("sim_state", act(), pack(0, 0, 0, 0, 3, 1, 4));
    cyc(0, 1, 0, 0, 0, 0);
    chk("sim_rereq", int'(rd_req), 1);

    // saturation, address wrap, lifetime counter wrap
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("fill4", int'(blocks_pending), 4);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ovf5", act(), pack(0, 0, 1, 0, 4, 0, 5));
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      while (!rd_req && k < 8) begin
        cyc(0, 1, 0, 0, 0, 0);
        k++;
      end
      chk($sformatf("req_wait%0d", i), int'(rd_req), 1);
      chk($sformatf("addr_seq%0d", i), int'(rd_addr), i);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("drained", act(), pack(0, 0, 1, 0, 0, 0, 5));
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_clr", int'(overflow_err), 0);
    for (int i = 0; i < 251; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("tot_wrap", act(), pack(0, 0, 1, 0, 4, 0, 0));

    // reset while a read is in flight
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("mid_busy", act(), pack(0, 1, 0, 0, 2, 0, 2));
    cyc(1, 0, 0, 0, 0, 0);
    chk("mid_rst", act(), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("post_rst_done", act(), pack(0, 0, 0, 1, 0, 0, 0));

    // randomized traffic against the model
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r, e, w, a, d, c;
      r = ($urandom_range(0, 199) == 0) ? 1 : 0;
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      w = ($urandom_range(0, 2) == 0) ? 1 : 0;
      a = (m_ph == 1) ? int'($urandom_range(0, 1))
                      : (($urandom_range(0, 31) == 0) ? 1 : 0);
      d = (m_ph == 2) ? (($urandom_range(0, 2) == 0) ? 1 : 0)
                      : (($urandom_range(0, 31) == 0) ? 1 : 0);
      c = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cyc(r, e, w, a, d, c);
      chk($sformatf("rand%0d", i), act(), mexp());
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
